// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = MD_WIDTH;

    // Quotient reported for a divide by zero. Wide enough for any practical
    // WIDTH; the top slices off what it needs.
    localparam logic [127:0] MD_DIV0_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_RUN = 3'd1,
        DIV_RUN = 3'd2,
        DONE_M  = 3'd3,
        DONE_D  = 3'd4
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used both as |x| and as result sign fix-up.
// Latency: combinational.
// Backpressure: none.
//
// Ports: val_i  value to correct
//        neg_i  1 = return -val_i, 0 = pass through
//        res_o  corrected value (W bits, wraps, so -2^(W-1) maps onto itself)
module md_sign_fix
    import mult_div_pkg::*;
#(
    parameter int W = MD_WIDTH
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) with HI/LO results.
// Latency: done in cycle T+33 after a start sampled at the end of cycle T; divide by zero done at T+2.
// Backpressure: none; starts are accepted only in IDLE and silently dropped otherwise.
//
// Ports: clk, reset_n (async, active low)
//        mult_start / div_start  one-cycle start pulses, mult wins if both are high
//        op_a / op_b             signed operands, sampled on the accepting edge
//        hi / lo                 product[2W-1:W]/product[W-1:0] or remainder/quotient
//        mult_done / div_done    one-cycle pulses, hi/lo valid in the same cycle
//        busy                    high from the cycle after the start edge through the done cycle
// Optional build macro: MULT_DIV_EARLY_EXIT_EN -- multiply stops as soon as the
// remaining multiplier bits are all zero (done at T+2 for op_b == 0).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done,
    output logic             div_done,
    output logic             busy
);

    localparam int CW = $clog2(ITERS) + 1;

    md_state_e          state_q, state_d;
    // Multiply: mag_a = multiplicand, mag_b = multiplier (shifts right).
    // Divide:   mag_a = dividend (shifts left), mag_b = divisor,
    //           acc[2W-1:W] = partial remainder, acc[W-1:0] = quotient bits.
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes, taken as unsigned so the most negative value survives.
    logic [WIDTH-1:0] op_a_mag, op_b_mag;

    md_sign_fix #(.W(WIDTH)) u_abs_a (.val_i(op_a), .neg_i(op_a[WIDTH-1]), .res_o(op_a_mag));
    md_sign_fix #(.W(WIDTH)) u_abs_b (.val_i(op_b), .neg_i(op_b[WIDTH-1]), .res_o(op_b_mag));

    // One multiply step: add multiplicand into the top half, shift the
    // 2W-bit accumulator right by one, carry entering from the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

    // One restoring divide step. The partial remainder is always below the
    // divisor (<= 2^(W-1)), so dropping its top bit on the left shift is safe.
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_acc;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        rem_sh  = {acc_q[2*WIDTH-2:WIDTH], mag_a_q[WIDTH-1]};
        trial   = {1'b0, rem_sh} - {1'b0, mag_b_q};
        q_bit   = ~trial[WIDTH];
        div_acc = {(q_bit ? trial[WIDTH-1:0] : rem_sh), acc_q[WIDTH-2:0], q_bit};
    end

    // Raw (unsigned) product presented to the fix-up on DONE_M entry.
    logic [2*WIDTH-1:0] prod_raw;
`ifdef MULT_DIV_EARLY_EXIT_EN
    // After k steps the accumulator holds the partial product scaled by
    // 2^(ITERS-k); when no multiplier bits remain, shift it into place.
    logic [CW-1:0] ee_shift;
    always_comb begin
        ee_shift = CW'(ITERS) - cnt_q;
        prod_raw = (mag_b_q == '0) ? (acc_q >> ee_shift) : mul_acc;
    end
`else
    assign prod_raw = mul_acc;
`endif

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val_i(prod_raw), .neg_i(sign_a_q ^ sign_b_q), .res_o(prod_fix));
    md_sign_fix #(.W(WIDTH)) u_fix_quot (
        .val_i(div_acc[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .res_o(quot_fix));
    // Divide by zero reports the original dividend in hi: re-signing the
    // untouched magnitude with sign_a reproduces op_a exactly.
    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val_i(div_zero_q ? mag_a_q : div_acc[2*WIDTH-1:WIDTH]),
        .neg_i(sign_a_q), .res_o(rem_fix));

    logic mul_step;

    always_comb begin
        state_d    = state_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mult_start || div_start) begin
                    mag_a_d    = op_a_mag;
                    mag_b_d    = op_b_mag;
                    sign_a_d   = op_a[WIDTH-1];
                    sign_b_d   = op_b[WIDTH-1];
                    acc_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = !mult_start && (op_b == '0);
                    state_d    = mult_start ? MUL_RUN : DIV_RUN;
                end
            end

            MUL_RUN: begin
`ifdef MULT_DIV_EARLY_EXIT_EN
                if (mag_b_q == '0) begin
                    state_d = DONE_M;
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fix[WIDTH-1:0];
                end else begin
                    mul_step = 1'b1;
                end
`else
                mul_step = 1'b1;
`endif
                if (mul_step) begin
                    acc_d   = mul_acc;
                    mag_b_d = mag_b_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        state_d = DONE_M;
                        hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d    = prod_fix[WIDTH-1:0];
                    end
                end
            end

            DIV_RUN: begin
                if (div_zero_q) begin
                    state_d = DONE_D;
                    hi_d    = rem_fix;
                    lo_d    = MD_DIV0_QUOT[WIDTH-1:0];
                end else begin
                    acc_d   = div_acc;
                    mag_a_d = mag_a_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        state_d = DONE_D;
                        hi_d    = rem_fix;
                        lo_d    = quot_fix;
                    end
                end
            end

            // Done lasts one cycle; a start seen here is deliberately dropped.
            DONE_M, DONE_D: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_done = (state_q == DONE_M);
    assign div_done  = (state_q == DONE_D);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] hi, lo;
    logic        mult_done, div_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .busy       (busy)
    );

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and watch 40 cycles. Cycle n=1 is the first cycle
    // after the accepting edge. extra_at > 0 pulses a foreign mult_start
    // (operands 9 x 9) during that cycle, which must be ignored.
    task automatic run_op(input string name, input logic is_div, input logic both,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input int extra_at);
        int first_done = 0;
        int mcnt = 0;
        int dcnt = 0;
        int busy_bad = 0;
        @(negedge clk);
        op_a       = a;
        op_b       = b;
        mult_start = !is_div || both;
        div_start  = is_div || both;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            mult_start = 1'b0;
            div_start  = 1'b0;
            op_a       = 32'hDEAD_BEEF;
            op_b       = 32'h0BAD_F00D;
            if (mult_done) mcnt++;
            if (div_done)  dcnt++;
            if (first_done == 0 && (is_div ? div_done : mult_done)) first_done = n;
            if (busy !== (n <= elat)) busy_bad++;
            if (n == extra_at) begin
                mult_start = 1'b1;
                op_a       = 32'd9;
                op_b       = 32'd9;
            end
        end
        check({name, " latency"}, 64'(first_done), 64'(elat));
        check({name, " hi"}, {32'h0, hi}, {32'h0, ehi});
        check({name, " lo"}, {32'h0, lo}, {32'h0, elo});
        check({name, " done pulses"}, 64'(is_div ? dcnt : mcnt), 64'd1);
        check({name, " other done"}, 64'(is_div ? mcnt : dcnt), 64'd0);
        check({name, " busy cycles wrong"}, 64'(busy_bad), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int mcnt;

        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[1] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[2] = '{1'b0, 32'h1234_5678,  32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 33};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};
        vecs[4] = '{1'b1, 32'd17,         32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5] = '{1'b1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[7] = '{1'b1, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 2};
        vecs[8] = '{1'b1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E, 33};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 2};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset hi", {32'h0, hi}, 64'h0);
        check("reset lo", {32'h0, lo}, 64'h0);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset mult_done", {63'h0, mult_done}, 64'h0);
        check("reset div_done", {63'h0, div_done}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].is_div, 1'b0, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat, 0);
        end

        // Both starts together: multiply only; a further mult_start at T+10 is ignored.
        run_op("both starts", 1'b0, 1'b1, 32'd7, 32'd6, 32'd0, 32'd42, 33, 10);
        // mult_start in the done cycle is dropped.
        run_op("start in done", 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF,
               32'hFFFF_FFF6, 33, 33);

        // Reset in the middle of a divide.
        @(negedge clk);
        op_a      = 32'd100;
        op_b      = 32'd7;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset hi", {32'h0, hi}, 64'h0);
        check("midreset lo", {32'h0, lo}, 64'h0);
        check("midreset busy", {63'h0, busy}, 64'h0);
        dcnt = 0;
        mcnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (div_done) dcnt++;
            if (mult_done) mcnt++;
        end
        reset_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (div_done) dcnt++;
            if (mult_done) mcnt++;
        end
        check("midreset no div_done", 64'(dcnt), 64'd0);
        check("midreset no mult_done", 64'(mcnt), 64'd0);
        check("midreset idle after", {63'h0, busy}, 64'h0);

        run_op("after reset 3x4", 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
